// File: rtl/spibuf_port_arbiter_pkg.sv
// Shared types and constants for the SPI transmit-buffer port-A arbiter.
package spibuf_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        ARB     = 2'd1,
        ISSUE   = 2'd2,
        RD_WAIT = 2'd3
    } arb_state_e;

    localparam logic [31:0] FILL_PATTERN_DEFAULT = 32'h5A6C_C6A5;

    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

endpackage

// File: rtl/spibuf_port_arbiter_if.sv
// Requester handshakes plus the port-A RAM bus of the SPI transmit buffer.
interface spibuf_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_gnt;
    logic              r0_rvalid;
    logic [DATA_W-1:0] r0_rdata;

    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_gnt;
    logic              r1_rvalid;
    logic [DATA_W-1:0] r1_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              init_done;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        input  mem_dout,
        output r0_gnt, r0_rvalid, r0_rdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output mem_we, mem_addr, mem_din, init_done
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        output mem_dout,
        input  r0_gnt, r0_rvalid, r0_rdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  mem_we, mem_addr, mem_din, init_done
    );
endinterface

// File: rtl/spibuf_port_arbiter_sync2.sv
// Two-flop synchronizer with a selectable reset value.
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/spibuf_port_arbiter.sv
// Port-A sequencer for the SPI transmit buffer: pattern fill after reset, then
// round-robin single-word access for host/debug with write lockout during SPI.
module spibuf_port_arbiter
    import spibuf_pkg::*;
#(
    parameter int                ADDR_W       = 10,
    parameter int                DATA_W       = 32,
    parameter logic [DATA_W-1:0] FILL_PATTERN = DATA_W'(FILL_PATTERN_DEFAULT),
    parameter int                RD_LATENCY   = 1
) (
    input  logic                 SysClk,
    input  logic                 Reset,
    input  logic                 spi_ss,
    spibuf_port_arbiter_if.slave bus
);
    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic [1:0]        lat_cnt_q, lat_cnt_d;
    logic              sel_q, sel_d;
    logic              last_q, last_d;
    logic              init_q, init_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic [DATA_W-1:0] rdata_q [2];
    logic [DATA_W-1:0] rdata_d [2];

    logic              spi_sync;
    logic [1:0]        req, we, elig;
    logic [ADDR_W-1:0] addr [2];
    logic [DATA_W-1:0] wdata [2];
    logic              pick;

    sync2 #(.RESET_VAL(1'b1)) u_ss_sync (
        .clk (SysClk),
        .rst (Reset),
        .d   (spi_ss),
        .q   (spi_sync)
    );

    // Writes are masked while the SPI side owns the buffer; reads always pass.
    always_comb begin
        req      = {bus.r1_req, bus.r0_req};
        we       = {bus.r1_we, bus.r0_we};
        addr[0]  = bus.r0_addr;
        addr[1]  = bus.r1_addr;
        wdata[0] = bus.r0_wdata;
        wdata[1] = bus.r1_wdata;
        elig     = req & ~(we & {2{~spi_sync}});
        if (&elig)
            pick = ~last_q;
        else if (elig[REQ_HOST])
            pick = REQ_HOST;
        else
            pick = REQ_DBG;
    end

    always_ff @(posedge SysClk) begin
        if (Reset) begin
            state_q     <= FILL;
            fill_addr_q <= '0;
            lat_cnt_q   <= '0;
            sel_q       <= REQ_HOST;
            last_q      <= REQ_DBG;
            init_q      <= 1'b0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            rdata_q[0]  <= '0;
            rdata_q[1]  <= '0;
        end else begin
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
            lat_cnt_q   <= lat_cnt_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            init_q      <= init_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            rdata_q[0]  <= rdata_d[0];
            rdata_q[1]  <= rdata_d[1];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (fill_addr_q == '1) state_d = ARB;
            ARB:     if (|elig) state_d = ISSUE;
            ISSUE:   state_d = mem_we_q ? ARB : RD_WAIT;
            RD_WAIT: if (lat_cnt_q == '0) state_d = ARB;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        fill_addr_d = fill_addr_q;
        lat_cnt_d   = lat_cnt_q;
        sel_d       = sel_q;
        last_d      = last_q;
        init_d      = init_q | (state_q == ARB);
        gnt_d       = '0;
        rvalid_d    = '0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        rdata_d     = rdata_q;
        case (state_q)
            FILL: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = fill_addr_q;
                mem_din_d   = FILL_PATTERN;
                fill_addr_d = fill_addr_q + ADDR_W'(1);
            end
            ARB: begin
                if (|elig) begin
                    sel_d       = pick;
                    last_d      = pick;
                    gnt_d[pick] = 1'b1;
                    mem_we_d    = we[pick];
                    mem_addr_d  = addr[pick];
                    mem_din_d   = wdata[pick];
                end
            end
            ISSUE: begin
                if (!mem_we_q) lat_cnt_d = 2'(RD_LATENCY - 1);
            end
            RD_WAIT: begin
                if (lat_cnt_q == '0) begin
                    rdata_d[sel_q]  = bus.mem_dout;
                    rvalid_d[sel_q] = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            default: ;
        endcase
    end

    assign bus.r0_gnt    = gnt_q[REQ_HOST];
    assign bus.r1_gnt    = gnt_q[REQ_DBG];
    assign bus.r0_rvalid = rvalid_q[REQ_HOST];
    assign bus.r1_rvalid = rvalid_q[REQ_DBG];
    assign bus.r0_rdata  = rdata_q[0];
    assign bus.r1_rdata  = rdata_q[1];
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_din   = mem_din_q;
    assign bus.init_done = init_q;
endmodule

// File: tb/tb_spibuf_port_arbiter.sv
// Scoreboard bench: two arbiters (read latency 1 and 3) on model RAMs.
module tb_spibuf_port_arbiter;
    localparam logic [31:0] PAT = 32'h5A6C_C6A5;

    logic SysClk = 1'b0;
    logic Reset  = 1'b1;
    logic spi_ss = 1'b1;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    always #5 SysClk = ~SysClk;
    always @(posedge SysClk) cyc <= cyc + 1;

    spibuf_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus_a ();
    spibuf_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus_b ();

    spibuf_port_arbiter #(.ADDR_W(10), .DATA_W(32), .FILL_PATTERN(PAT), .RD_LATENCY(1)) dut_a (
        .SysClk(SysClk), .Reset(Reset), .spi_ss(spi_ss), .bus(bus_a));
    spibuf_port_arbiter #(.ADDR_W(10), .DATA_W(32), .FILL_PATTERN(PAT), .RD_LATENCY(3)) dut_b (
        .SysClk(SysClk), .Reset(Reset), .spi_ss(spi_ss), .bus(bus_b));

    // Model RAMs: read data appears RD_LATENCY cycles after the address.
    logic [31:0] ram_a [1024];
    logic [31:0] ram_b [1024];
    logic [31:0] pipe_a;
    logic [31:0] pipe_b [3];
    always @(posedge SysClk) begin
        if (bus_a.mem_we) ram_a[bus_a.mem_addr] <= bus_a.mem_din;
        if (bus_b.mem_we) ram_b[bus_b.mem_addr] <= bus_b.mem_din;
        pipe_a    <= ram_a[bus_a.mem_addr];
        pipe_b[0] <= ram_b[bus_b.mem_addr];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign bus_a.mem_dout = pipe_a;
    assign bus_b.mem_dout = pipe_b[2];

    typedef struct {
        int          kind;   // 0/1 = gnt r0/r1, 2/3 = rvalid r0/r1
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t q_a[$];
    exp_t q_b[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int dut, input int kind, input logic [31:0] data, input int at);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.cyc  = at;
        if (dut == 0) q_a.push_back(e);
        else          q_b.push_back(e);
    endtask

    task automatic mon_event(input int dut, input int kind, input logic [31:0] data);
        exp_t e;
        if ((dut == 0 && q_a.size() == 0) || (dut == 1 && q_b.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: dut %0d kind %0d at cyc %0d, none expected", dut, kind, cyc);
            return;
        end
        if (dut == 0) e = q_a.pop_front();
        else          e = q_b.pop_front();
        chk(dut == 0 ? "a_event_kind" : "b_event_kind", kind, e.kind);
        chk(dut == 0 ? "a_event_cyc" : "b_event_cyc", cyc, e.cyc);
        if (kind >= 2) chk(dut == 0 ? "a_rdata" : "b_rdata", data, e.data);
    endtask

    always @(negedge SysClk) begin
        if (bus_a.r0_gnt)    mon_event(0, 0, 32'h0);
        if (bus_a.r1_gnt)    mon_event(0, 1, 32'h0);
        if (bus_a.r0_rvalid) mon_event(0, 2, bus_a.r0_rdata);
        if (bus_a.r1_rvalid) mon_event(0, 3, bus_a.r1_rdata);
        if (bus_b.r0_gnt)    mon_event(1, 0, 32'h0);
        if (bus_b.r1_gnt)    mon_event(1, 1, 32'h0);
        if (bus_b.r0_rvalid) mon_event(1, 2, bus_b.r0_rdata);
        if (bus_b.r1_rvalid) mon_event(1, 3, bus_b.r1_rdata);
    end

    task automatic tick();
        @(posedge SysClk);
        #1;
    endtask

    task automatic drive(input int dut, input int n, input logic req, input logic we,
                         input logic [9:0] addr, input logic [31:0] wd);
        if (dut == 0 && n == 0) begin
            bus_a.r0_req = req; bus_a.r0_we = we; bus_a.r0_addr = addr; bus_a.r0_wdata = wd;
        end else if (dut == 0) begin
            bus_a.r1_req = req; bus_a.r1_we = we; bus_a.r1_addr = addr; bus_a.r1_wdata = wd;
        end else if (n == 0) begin
            bus_b.r0_req = req; bus_b.r0_we = we; bus_b.r0_addr = addr; bus_b.r0_wdata = wd;
        end else begin
            bus_b.r1_req = req; bus_b.r1_we = we; bus_b.r1_addr = addr; bus_b.r1_wdata = wd;
        end
    endtask

    function automatic logic get_gnt(input int dut, input int n);
        if (dut == 0) return (n == 0) ? bus_a.r0_gnt : bus_a.r1_gnt;
        return (n == 0) ? bus_b.r0_gnt : bus_b.r1_gnt;
    endfunction

    task automatic drain(input int bound);
        int n = 0;
        while ((q_a.size() + q_b.size()) > 0 && n < bound) begin
            tick();
            n++;
        end
        chk("outstanding_events", q_a.size() + q_b.size(), 0);
    endtask

    // Single access on an idle arbiter: gnt one cycle after the sampling edge,
    // rvalid 2+lat cycles after it.
    task automatic do_req(input int dut, input int n, input logic we, input logic [9:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd_exp, input int lat);
        int c = cyc;
        int k = 0;
        drive(dut, n, 1'b1, we, addr, wd);
        push(dut, n, 32'h0, c + 1);
        if (!we) push(dut, 2 + n, rd_exp, c + 2 + lat);
        while (!get_gnt(dut, n) && k < 20) begin
            tick();
            k++;
        end
        if (!get_gnt(dut, n)) begin
            checks++;
            failures++;
            $display("FAIL gnt_timeout: dut %0d req %0d got no gnt within 20 cycles", dut, n);
        end
        drive(dut, n, 1'b0, 1'b0, 10'h0, 32'h0);
        drain(20);
    endtask

    initial begin
        int r, c, d, k, bad;
        for (int i = 0; i < 2; i++) begin
            drive(0, i, 1'b0, 1'b0, 10'h0, 32'h0);
            drive(1, i, 1'b0, 1'b0, 10'h0, 32'h0);
        end
        repeat (3) tick();
        chk("reset_ctl", {bus_a.r0_gnt, bus_a.r1_gnt, bus_a.r0_rvalid, bus_a.r1_rvalid,
                          bus_a.mem_we, bus_a.init_done}, 0);
        chk("reset_bus", {bus_a.mem_addr, bus_a.mem_din}, 0);
        chk("reset_rdata", {bus_a.r0_rdata, bus_a.r1_rdata}, 0);

        // Requests raised before fill: must wait for fill to finish.
        drive(0, 0, 1'b1, 1'b1, 10'h155, 32'hCAFE_0001);
        drive(1, 0, 1'b1, 1'b1, 10'h010, 32'hAAAA_0000);
        drive(1, 1, 1'b1, 1'b1, 10'h020, 32'hBBBB_0000);
        tick();
        r = cyc;
        Reset = 1'b0;
        push(0, 0, 32'h0, r + 1025);
        for (int i = 0; i < 6; i++) push(1, i % 2, 32'h0, r + 1025 + 2 * i);

        bad = 0;
        @(posedge SysClk);
        for (int i = 0; i < 1024; i++) begin
            @(negedge SysClk);
            if (bus_a.mem_we !== 1'b1 || bus_a.mem_addr !== 10'(i) || bus_a.mem_din !== PAT ||
                bus_a.init_done !== 1'b0)
                bad++;
        end
        chk("fill_seq_errors", bad, 0);
        @(negedge SysClk);
        chk("init_rise", bus_a.init_done, 1);
        chk("first_write", {bus_a.mem_we, bus_a.mem_addr, bus_a.mem_din}, {1'b1, 10'h155, 32'hCAFE_0001});
        drive(0, 0, 1'b0, 1'b0, 10'h0, 32'h0);

        // Contention on dut_b: hold both writes through six alternating grants.
        while (cyc < r + 1036) tick();
        drive(1, 0, 1'b0, 1'b0, 10'h0, 32'h0);
        drive(1, 1, 1'b0, 1'b0, 10'h0, 32'h0);
        drain(10);

        do_req(0, 1, 1'b0, 10'h155, 32'h0, 32'hCAFE_0001, 1);
        do_req(0, 0, 1'b0, 10'h3FF, 32'h0, PAT, 1);
        do_req(1, 0, 1'b1, 10'h155, 32'h1234_5678, 32'h0, 3);
        do_req(1, 1, 1'b0, 10'h155, 32'h0, 32'h1234_5678, 3);

        // SPI lockout: write held, read passes; write issues after release.
        spi_ss = 1'b0;
        repeat (3) tick();
        c = cyc;
        drive(0, 0, 1'b1, 1'b1, 10'h2AA, 32'hBEEF_0002);
        drive(0, 1, 1'b1, 1'b0, 10'h200, 32'h0);
        push(0, 1, 32'h0, c + 1);
        push(0, 3, PAT, c + 3);
        tick();
        drive(0, 1, 1'b0, 1'b0, 10'h0, 32'h0);
        repeat (4) tick();
        d = cyc;
        spi_ss = 1'b1;
        push(0, 0, 32'h0, d + 3);
        k = 0;
        while (!bus_a.r0_gnt && k < 10) begin
            tick();
            k++;
        end
        if (!bus_a.r0_gnt) begin
            checks++;
            failures++;
            $display("FAIL lockout_release_timeout: r0 write not granted within 10 cycles");
        end
        drive(0, 0, 1'b0, 1'b0, 10'h0, 32'h0);
        drain(10);
        do_req(0, 1, 1'b0, 10'h2AA, 32'h0, 32'hBEEF_0002, 1);

        // Reset during RD_WAIT: no rvalid, fill restarts from address 0.
        c = cyc;
        drive(0, 1, 1'b1, 1'b0, 10'h155, 32'h0);
        push(0, 1, 32'h0, c + 1);
        tick();
        drive(0, 1, 1'b0, 1'b0, 10'h0, 32'h0);
        tick();
        Reset = 1'b1;
        repeat (2) tick();
        chk("reset2_rdata", {bus_a.r0_rdata, bus_a.r1_rdata}, 0);
        chk("reset2_ctl", {bus_a.r1_rvalid, bus_a.mem_we, bus_a.init_done}, 0);
        tick();
        r = cyc;
        Reset = 1'b0;
        @(posedge SysClk);
        @(negedge SysClk);
        chk("refill_start", {bus_a.mem_we, bus_a.mem_addr, bus_a.init_done}, {1'b1, 10'h000, 1'b0});
        k = 0;
        while (bus_a.init_done !== 1'b1 && k < 1100) begin
            @(negedge SysClk);
            k++;
        end
        chk("refill_init_cyc", cyc, r + 1025);
        repeat (4) tick();
        drain(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spibuf_port_arbiter.md
# spibuf_port_arbiter

Sequences and shares the SysClk-side port (port A) of the SPI transmit buffer RAM. After reset it fills every word with a fixed pattern. It then arbitrates single-word read/write accesses between two requesters (0: host, 1: debug/readback) using round-robin. While an SPI transfer is in progress, writes are held off so the SPI-clock side never reads a half-updated buffer.

## Interface
- ADDR_W, 10, port-A word address width (buffer depth 2^ADDR_W)
- DATA_W, 32, port-A word width
- FILL_PATTERN, 32'h5A6C_C6A5, word written to every address during fill
- RD_LATENCY, 1, RAM cycles from address to valid mem_dout (1..3)
- SysClk  in  1  clock; all logic on rising edge
- Reset  in  1  synchronous, active-high
- spi_ss  in  1  SPI slave select, active-low, asynchronous to SysClk
- rN_req  in  1  (N=0,1) access request; held until rN_gnt seen
- rN_we  in  1  1=write, 0=read; stable while rN_req high
- rN_addr  in  ADDR_W  word address; stable while rN_req high
- rN_wdata  in  DATA_W  write data; stable while rN_req high
- rN_gnt  out  1  one-cycle pulse: access issued this cycle
- rN_rvalid  out  1  one-cycle pulse: rN_rdata valid
- rN_rdata  out  DATA_W  read data; holds last value
- mem_we  out  1  port-A write enable
- mem_addr  out  ADDR_W  port-A address
- mem_din  out  DATA_W  port-A write data
- mem_dout  in  DATA_W  port-A read data
- init_done  out  1  high once fill is complete; stays high until Reset

## Operation
- States: FILL, ARB, ISSUE, RD_WAIT.
- Reset: state=FILL, fill address=0, round-robin pointer favours requester 0.
- Outputs during a Reset cycle: all gnt, rvalid and mem_we = 0; all rdata, mem_addr and mem_din = 0; init_done = 0.
- FILL:
  - mem_we=1, mem_din=FILL_PATTERN, mem_addr increments by 1 each cycle from 0.
  - After writing address 2^ADDR_W-1, go to ARB; init_done=1 from the next cycle.
  - Requests are ignored (no gnt) during FILL.
- ARB:
  - Eligible = req high, excluding write requests while SPI is active (synchronized spi_ss == 0).
  - No eligible requester: stay in ARB.
  - One eligible requester: select it.
  - Both eligible: select the requester not granted last. Pointer updates on every grant.
- ISSUE (one cycle):
  - Registered mem_addr/mem_we/mem_din from the selected requester; its gnt=1.
  - After a write: go to ARB.
  - After a read: go to RD_WAIT.
- RD_WAIT:
  - Lasts RD_LATENCY cycles; captures mem_dout into rN_rdata.
  - rN_rvalid pulses in the first ARB cycle after RD_WAIT.
  - Arbitration resumes in that same cycle.
- Requester protocol: drop req (or present a new request) in the cycle after gnt. The cycle following ISSUE never grants, so a held req is not double-granted.
- spi_ss: two-flop synchronizer, reset to 1 (inactive).
  - Lockout is evaluated only in ARB; an already issued write completes.
  - A locked-out write stays pending and does not block the other requester's read.
- mem_we=0 outside FILL and write ISSUE cycles. mem_addr/mem_din hold their last value.
- Reset mid-operation (any state): abort, re-enter FILL at address 0, no rvalid for an aborted read.

## Timing
- Fill: 2^ADDR_W cycles (1024 by default); init_done rises cycle 1025 after Reset deasserts.
- Write: req sampled in ARB at edge k; gnt and mem_we high in cycle k+1. Minimum 2 cycles per write.
- Read: gnt in cycle k+1; rvalid in cycle k+2+RD_LATENCY. Minimum 2+RD_LATENCY cycles per read.
- spi_ss to lockout: 2-3 SysClk cycles.

## Structure
- Shared package spibuf_pkg holds:
  - state enum (FILL, ARB, ISSUE, RD_WAIT)
  - default FILL_PATTERN constant
  - requester-index constants REQ_HOST=0, REQ_DBG=1
- Sub-module sync2 (two-flop synchronizer, parameterized reset value), used for spi_ss.
- Round-robin select is inline logic.

## Test plan
- Fill: release Reset → mem_we high for 1024 consecutive cycles, addresses 0..1023, data 32'h5A6C_C6A5; init_done rises cycle 1025.
- Requests during fill: r0 write requested during fill → no gnt until init_done; then gnt exactly once.
- Contention: r0 and r1 hold write requests continuously → grants alternate r0, r1, r0, ...; first grant after fill goes to r0.
- Read: r1 reads address 0x155 with model RAM, RD_LATENCY=1 → gnt at k+1, r1_rvalid at k+3, r1_rdata = RAM[0x155]; repeat with RD_LATENCY=3 → rvalid at k+5.
- SPI lockout: spi_ss=0, r0 write and r1 read pending → r1 granted, r0 held; spi_ss=1 → r0 granted within 4 cycles.
- Reset mid-read: assert Reset during RD_WAIT → no rvalid; mem_addr restarts at 0 in FILL; init_done low until the fill completes again.
